if_fetch_unit: RTL and testbench

- Instruction-fetch stage of the sccpu core. Sits upstream of decode/EXT and consumes EXT's sign-extended immediate for control-flow redirects.
- Owns the PC register and computes next-PC (PC+4, branch/JAL target, JALR target).
- Issues one-outstanding-request fetches to instruction memory over a req/gnt/rvalid handshake.
- Hands the fetched instruction and its PC to decode over a valid/ready handshake.

---
 rtl/if_fetch_unit_pkg.sv | 14 +
 rtl/if_fetch_unit_npc.sv | 17 +
 rtl/if_fetch_unit.sv | 95 +++++++++
 tb/tb_if_fetch_unit.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg: next-PC select codes and fetch FSM encodings shared by the fetch stage
package if_fetch_unit_pkg;
    typedef enum logic [1:0] {
        NPC_NONE   = 2'b00,
        NPC_BRANCH = 2'b01,
        NPC_JAL    = 2'b10,
        NPC_JALR   = 2'b11
    } npc_op_e;
    typedef enum logic [1:0] {
        IF_FETCH = 2'b00,
        IF_WAIT  = 2'b01,
        IF_EXC   = 2'b10
    } if_state_e;
endpackage

// File: rtl/if_fetch_unit_npc.sv
// if_npc: sequential next-PC, redirect target adder and misalign detect
module if_npc
    import if_fetch_unit_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  npc_op,
    input  logic [31:0] br_pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] immout,
    output logic [31:0] seq_pc,
    output logic [31:0] target,
    output logic        misalign
);
    assign seq_pc   = pc + 32'd4;
    assign target   = (npc_op == NPC_JALR) ? ((rs1_data + immout) & ~32'h1) : (br_pc + immout);
    assign misalign = target[1];
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC register, single-outstanding imem fetch FSM and decode output register
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] PC_RESET  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic        id_exc,
    input  logic        redirect_valid,
    input  logic [1:0]  npc_op,
    input  logic [31:0] br_pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] immout
);
    if_state_e   state;
    logic [31:0] pc_q, seq_pc, target;
    logic        drop_q, started_q, misalign, redirect, granted, outstanding, load, consume;

    if_npc u_npc (
        .pc       (pc_q),
        .npc_op   (npc_op),
        .br_pc    (br_pc),
        .rs1_data (rs1_data),
        .immout   (immout),
        .seq_pc   (seq_pc),
        .target   (target),
        .misalign (misalign)
    );

    assign redirect  = redirect_valid && (npc_op != NPC_NONE);
    assign imem_req  = started_q && (state == IF_FETCH) && (!id_valid || id_ready);
    assign imem_addr = pc_q;
    assign granted   = imem_req && imem_gnt;
    assign consume   = id_valid && id_ready;
    assign load      = (state == IF_WAIT) && imem_rvalid && !drop_q;
    // a response still owed by imem after this cycle must be dropped once a redirect lands
    assign outstanding = granted || (((state == IF_WAIT) || drop_q) && !imem_rvalid);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IF_FETCH;
            pc_q      <= PC_RESET;
            drop_q    <= 1'b0;
            started_q <= 1'b0;
            id_valid  <= 1'b0;
            id_instr  <= NOP_INSTR;
            id_pc     <= '0;
            id_exc    <= 1'b0;
        end else begin
            started_q <= 1'b1;
            if (redirect) begin
                pc_q     <= target;
                drop_q   <= outstanding;
                state    <= misalign ? IF_EXC : (outstanding ? IF_WAIT : IF_FETCH);
                id_valid <= misalign;
                id_exc   <= misalign;
                id_instr <= NOP_INSTR;
                if (misalign)
                    id_pc <= target;
            end else begin
                case (state)
                    IF_FETCH: if (granted) state <= IF_WAIT;
                    IF_WAIT: if (imem_rvalid) begin
                        state  <= IF_FETCH;
                        drop_q <= 1'b0;
                        if (!drop_q)
                            pc_q <= seq_pc;
                    end
                    default: if (imem_rvalid) drop_q <= 1'b0;
                endcase
                if (load) begin
                    id_valid <= 1'b1;
                    id_instr <= imem_rdata;
                    id_pc    <= pc_q;
                    id_exc   <= 1'b0;
                end else if (consume) begin
                    id_valid <= 1'b0;
                    id_instr <= NOP_INSTR;
                    id_exc   <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed fetch/redirect/reset scenarios checked against a transaction-level model
module tb_if_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;
    logic        clk = 1'b0, rstn = 1'b0;
    logic        imem_req, imem_gnt, id_valid, id_exc;
    logic        imem_rvalid = 1'b0, id_ready = 1'b1, redirect_valid = 1'b0;
    logic [31:0] imem_addr, id_instr, id_pc;
    logic [31:0] imem_rdata = '0, br_pc = '0, rs1_data = '0, immout = '0;
    logic [1:0]  npc_op = 2'b00;
    int          resp_delay = 0;
    int          vectors = 0, errors = 0;

    always #5 clk = ~clk;
    assign imem_gnt = imem_req;

    if_fetch_unit dut (
        .clk            (clk),
        .rstn           (rstn),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_exc         (id_exc),
        .redirect_valid (redirect_valid),
        .npc_op         (npc_op),
        .br_pc          (br_pc),
        .rs1_data       (rs1_data),
        .immout         (immout)
    );

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0050_0093 : {a[23:0], 8'h13};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!id_valid && n < 20);
        vectors++;
        if (!id_valid) begin
            errors++;
            $display("FAIL %s: id_valid still low after 20 cycles", name);
        end
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!imem_req && n < 20);
        vectors++;
        if (!imem_req) begin
            errors++;
            $display("FAIL %s: imem_req still low after 20 cycles", name);
        end
    endtask

    task automatic redirect(input logic [1:0] op, input logic [31:0] bp, input logic [31:0] rs1, input logic [31:0] imm);
        redirect_valid = 1'b1;
        npc_op = op;
        br_pc = bp;
        rs1_data = rs1;
        immout = imm;
    endtask

    // imem: grant whatever is requested, answer resp_delay cycles later, never while in reset
    initial begin
        logic [31:0] a;
        forever begin
            @(negedge clk);
            if (imem_req && imem_gnt) begin
                a = imem_addr;
                @(posedge clk);
                repeat (resp_delay) @(posedge clk);
                #1;
                if (rstn) begin
                    imem_rvalid = 1'b1;
                    imem_rdata = mem(a);
                end
                @(posedge clk);
                #1 imem_rvalid = 1'b0;
            end
        end
    end

    // model: fetch pointer, one in-flight request that may be marked for discard, and the decode slot
    logic        m_started, m_inflight, m_discard, m_halted, m_valid, m_exc, exp_req, redir, resp, loaded;
    logic [31:0] m_pc, m_instr, m_id_pc, tgt;
    always @(negedge clk) begin
        if (!rstn) begin
            m_started = 0; m_inflight = 0; m_discard = 0; m_halted = 0;
            m_valid = 0; m_exc = 0; m_pc = 32'h0; m_instr = NOP; m_id_pc = 32'h0;
        end
        exp_req = m_started && !m_inflight && !m_halted && (!m_valid || id_ready);
        check("imem_req", 32'(imem_req), 32'(exp_req));
        check("imem_addr", imem_addr, m_pc);
        check("id_valid", 32'(id_valid), 32'(m_valid));
        check("id_instr", id_instr, m_instr);
        check("id_pc", id_pc, m_id_pc);
        check("id_exc", 32'(id_exc), 32'(m_exc));
        if (rstn) begin
            redir = redirect_valid && (npc_op != 2'b00);
            tgt = (npc_op == 2'b11) ? ((rs1_data + immout) & ~32'h1) : (br_pc + immout);
            resp = imem_rvalid && m_inflight;
            m_started = 1;
            if (redir) begin
                m_inflight = exp_req || (m_inflight && !resp);
                m_discard = m_inflight;
                m_pc = tgt;
                m_halted = tgt[1];
                m_valid = tgt[1];
                m_exc = tgt[1];
                m_instr = NOP;
                if (tgt[1]) m_id_pc = tgt;
            end else begin
                loaded = resp && !m_discard;
                if (resp) begin
                    m_inflight = 0;
                    m_discard = 0;
                end
                if (loaded) begin
                    m_valid = 1; m_instr = imem_rdata; m_id_pc = m_pc; m_exc = 0; m_pc = m_pc + 32'd4;
                end else if (m_valid && id_ready) begin
                    m_valid = 0; m_instr = NOP; m_exc = 0;
                end
                if (exp_req) m_inflight = 1;
            end
        end
    end

    initial begin
        repeat (3) tick();
        check("rst_req", 32'(imem_req), 32'h0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", 32'(id_valid), 32'h0);
        check("rst_instr", id_instr, 32'h0000_0013);
        check("rst_pc", id_pc, 32'h0);
        check("rst_exc", 32'(id_exc), 32'h0);
        rstn = 1'b1;
        tick();
        check("first_req", 32'(imem_req), 32'h1);
        check("first_addr", imem_addr, 32'h0);
        wait_valid("first_valid");
        check("first_pc", id_pc, 32'h0);
        check("first_instr", id_instr, 32'h0050_0093);
        check("next_addr", imem_addr, 32'h4);

        wait_valid("second_valid");
        id_ready = 1'b0;
        check("stall_pc0", id_pc, 32'h4);
        repeat (5) begin
            tick();
            check("stall_valid", 32'(id_valid), 32'h1);
            check("stall_pc", id_pc, 32'h4);
            check("stall_instr", id_instr, 32'h0000_0413);
            check("stall_req", 32'(imem_req), 32'h0);
        end
        resp_delay = 2;
        id_ready = 1'b1;
        #1;
        check("consume_req", 32'(imem_req), 32'h1);
        check("consume_addr", imem_addr, 32'h8);

        tick();
        resp_delay = 0;
        redirect(2'b01, 32'h100, 32'h0, 32'hFFFF_FFF0);
        tick();
        redirect_valid = 1'b0;
        npc_op = 2'b00;
        check("br_nop", id_instr, 32'h0000_0013);
        wait_req("br_req");
        check("br_addr", imem_addr, 32'h0000_00F0);
        check("br_novalid", 32'(id_valid), 32'h0);
        wait_valid("br_valid");
        check("br_pc", id_pc, 32'h0000_00F0);
        check("br_instr", id_instr, 32'h0000_F013);

        redirect(2'b11, 32'h0, 32'h2001, 32'h3);
        tick();
        redirect_valid = 1'b0;
        npc_op = 2'b00;
        check("jalr_clear", 32'(id_valid), 32'h0);
        wait_req("jalr_req");
        check("jalr_addr", imem_addr, 32'h0000_2004);
        wait_valid("jalr_valid");
        check("jalr_pc", id_pc, 32'h0000_2004);
        check("jalr_instr", id_instr, 32'h0020_0413);

        redirect(2'b10, 32'h10, 32'h0, 32'h2);
        tick();
        redirect_valid = 1'b0;
        npc_op = 2'b00;
        id_ready = 1'b0;
        check("exc_valid", 32'(id_valid), 32'h1);
        check("exc_flag", 32'(id_exc), 32'h1);
        check("exc_pc", id_pc, 32'h0000_0012);
        check("exc_instr", id_instr, 32'h0000_0013);
        repeat (4) begin
            tick();
            check("exc_noreq", 32'(imem_req), 32'h0);
            check("exc_hold", 32'(id_exc), 32'h1);
        end

        id_ready = 1'b1;
        redirect(2'b10, 32'hFFFF_FFF0, 32'h0, 32'hC);
        tick();
        redirect_valid = 1'b0;
        npc_op = 2'b00;
        check("wrap_req", 32'(imem_req), 32'h1);
        check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        check("wrap_exc", 32'(id_exc), 32'h0);
        wait_valid("wrap_valid");
        check("wrap_pc", id_pc, 32'hFFFF_FFFC);
        check("wrap_instr", id_instr, 32'hFFFF_FC13);
        check("wrap_next", imem_addr, 32'h0);

        wait_valid("zero_valid");
        check("zero_pc", id_pc, 32'h0);
        resp_delay = 2;
        tick();
        #2 rstn = 1'b0;
        #1;
        check("arst_req", 32'(imem_req), 32'h0);
        check("arst_addr", imem_addr, 32'h0);
        check("arst_valid", 32'(id_valid), 32'h0);
        check("arst_instr", id_instr, 32'h0000_0013);
        check("arst_exc", 32'(id_exc), 32'h0);
        repeat (3) tick();
        resp_delay = 0;
        rstn = 1'b1;
        tick();
        check("rerun_req", 32'(imem_req), 32'h1);
        check("rerun_addr", imem_addr, 32'h0);
        wait_valid("rerun_valid");
        check("rerun_instr", id_instr, 32'h0050_0093);
        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
